// File: rtl/rfile_pkg.sv
// Shared types and default sizes for the multi-port register file and the decode stage.
package rfile_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NUM_REG    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } rf_clr_state_e;

endpackage

// File: rtl/rfile_clr_fsm.sv
// Sequenced clear engine: walks every register once, then pulses clr_done.
module rfile_clr_fsm
  import rfile_pkg::*;
#(
  parameter int NUM_REG    = RF_NUM_REG,
  parameter int ADDR_WIDTH = $clog2(NUM_REG)
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_idle
);

  // The extra pointer bit lets a power-of-two NUM_REG finish without wrapping.
  localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(NUM_REG - 1);

  rf_clr_state_e         r_state;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_idle;

  // State, pointer and registered status flags.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (clr_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_idle  <= 1'b0;
          end
        end
        CLEAR: begin
          r_ptr <= r_ptr + (ADDR_WIDTH+1)'(1);
          if (r_ptr == LAST_PTR) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_idle  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ptr   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_busy = r_busy;
  assign clr_done = r_done;
  assign clr_we   = r_busy;
  assign clr_addr = r_ptr[ADDR_WIDTH-1:0];
  assign clr_idle = r_idle;

endmodule

// File: rtl/rfile_mp.sv
// Multi-port register file with two prioritised write ports, write-to-read bypass,
// a per-register pending scoreboard and a hardware clear engine.
module rfile_mp
  import rfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REG    = RF_NUM_REG,
  parameter int ADDR_WIDTH = $clog2(NUM_REG),
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                                 Clk,
  input  logic                                 reset_n,
  input  logic                                 wr0_en,
  input  logic [ADDR_WIDTH-1:0]                wr0_addr,
  input  logic [DATA_WIDTH-1:0]                wr0_data,
  input  logic                                 wr1_en,
  input  logic [ADDR_WIDTH-1:0]                wr1_addr,
  input  logic [DATA_WIDTH-1:0]                wr1_data,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]                    rd_pending,
  input  logic                                 sb_set_en,
  input  logic [ADDR_WIDTH-1:0]                sb_set_addr,
  input  logic                                 clr_req,
  output logic                                 clr_busy,
  output logic                                 clr_done
);

  localparam logic [ADDR_WIDTH:0] REG_CNT = (ADDR_WIDTH+1)'(NUM_REG);
  localparam bit                  ZR      = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] r_mem [NUM_REG];
  logic [NUM_REG-1:0]    r_sb;

  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_idle;
  logic                  w_wr0_ok;
  logic                  w_wr1_ok;
  logic                  w_set_ok;
  logic [NUM_REG-1:0]    w_wr0_hit;
  logic [NUM_REG-1:0]    w_wr1_hit;
  logic [NUM_REG-1:0]    w_set_hit;
  logic [NUM_REG-1:0]    w_clr_hit;
  logic [NUM_REG-1:0]    w_sb_next;
  logic [NUM_RD-1:0]     w_byp0;
  logic [NUM_RD-1:0]     w_byp1;

  // An address is backed by storage if it is in range and not the hardwired zero.
  function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < REG_CNT) && !(ZR && (a == '0));
  endfunction

  rfile_clr_fsm #(
    .NUM_REG    (NUM_REG),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr_fsm (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .clr_idle (w_idle)
  );

  assign w_wr0_ok = wr0_en    && w_idle && addr_live(wr0_addr);
  assign w_wr1_ok = wr1_en    && w_idle && addr_live(wr1_addr);
  assign w_set_ok = sb_set_en && w_idle && addr_live(sb_set_addr);

  // Per-register decode of every update source and the next scoreboard value.
  always_comb begin
    w_wr0_hit = '0;
    w_wr1_hit = '0;
    w_set_hit = '0;
    w_clr_hit = '0;
    w_sb_next = r_sb;
    for (int r = 0; r < NUM_REG; r++) begin
      w_wr0_hit[r] = w_wr0_ok && (wr0_addr    == ADDR_WIDTH'(r));
      w_wr1_hit[r] = w_wr1_ok && (wr1_addr    == ADDR_WIDTH'(r));
      w_set_hit[r] = w_set_ok && (sb_set_addr == ADDR_WIDTH'(r));
      w_clr_hit[r] = w_clr_we && (w_clr_addr  == ADDR_WIDTH'(r));
      // A new producer issued in the same cycle as a writeback keeps the bit set.
      if (w_clr_hit[r]) begin
        w_sb_next[r] = 1'b0;
      end else if (w_set_hit[r]) begin
        w_sb_next[r] = 1'b1;
      end else if (w_wr0_hit[r] || w_wr1_hit[r]) begin
        w_sb_next[r] = 1'b0;
      end else begin
        w_sb_next[r] = r_sb[r];
      end
    end
  end

  // Storage and scoreboard update; port 1 overrides port 0 on a shared address.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REG; r++) begin
        r_mem[r] <= '0;
      end
      r_sb <= '0;
    end else begin
      for (int r = 0; r < NUM_REG; r++) begin
        if (w_clr_hit[r]) begin
          r_mem[r] <= '0;
        end else if (w_wr1_hit[r]) begin
          r_mem[r] <= wr1_data;
        end else if (w_wr0_hit[r]) begin
          r_mem[r] <= wr0_data;
        end
      end
      r_sb <= w_sb_next;
    end
  end

  // Read ports with bypass; outside IDLE the write oks are low, so no bypass occurs.
  always_comb begin
    w_byp0     = '0;
    w_byp1     = '0;
    rd_data    = '0;
    rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_byp1[i] = w_wr1_ok && (wr1_addr == rd_addr[i]);
      w_byp0[i] = w_wr0_ok && (wr0_addr == rd_addr[i]);
      if (w_byp1[i]) begin
        rd_data[i] = wr1_data;
      end else if (w_byp0[i]) begin
        rd_data[i] = wr0_data;
      end else if (addr_live(rd_addr[i])) begin
        rd_data[i] = r_mem[rd_addr[i]];
      end else begin
        rd_data[i] = '0;
      end
      rd_pending[i] = addr_live(rd_addr[i]) && r_sb[rd_addr[i]] && !(w_byp0[i] || w_byp1[i]);
    end
  end

endmodule

// File: tb/tb_rfile_mp.sv
// Scoreboard bench for rfile_mp: a default instance and a 4-port/16-reg/no-zero-reg instance.
module tb_rfile_mp;

  localparam int K_DATA = 0;
  localparam int K_PEND = 1;
  localparam int K_BUSY = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    int          port;
    logic [31:0] ev;
    string       name;
  } exp_t;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];

  logic             a_wr0_en, a_wr1_en, a_sb_set_en, a_clr_req, a_clr_busy, a_clr_done;
  logic [4:0]       a_wr0_addr, a_wr1_addr, a_sb_set_addr;
  logic [31:0]      a_wr0_data, a_wr1_data;
  logic [1:0][4:0]  a_rd_addr;
  logic [1:0][31:0] a_rd_data;
  logic [1:0]       a_rd_pend;

  logic             b_wr0_en, b_wr1_en, b_sb_set_en, b_clr_req, b_clr_busy, b_clr_done;
  logic [3:0]       b_wr0_addr, b_wr1_addr, b_sb_set_addr;
  logic [31:0]      b_wr0_data, b_wr1_data;
  logic [3:0][3:0]  b_rd_addr;
  logic [3:0][31:0] b_rd_data;
  logic [3:0]       b_rd_pend;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  rfile_mp u_a (
    .Clk(Clk), .reset_n(reset_n),
    .wr0_en(a_wr0_en), .wr0_addr(a_wr0_addr), .wr0_data(a_wr0_data),
    .wr1_en(a_wr1_en), .wr1_addr(a_wr1_addr), .wr1_data(a_wr1_data),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_pending(a_rd_pend),
    .sb_set_en(a_sb_set_en), .sb_set_addr(a_sb_set_addr),
    .clr_req(a_clr_req), .clr_busy(a_clr_busy), .clr_done(a_clr_done)
  );

  rfile_mp #(.DATA_WIDTH(32), .NUM_REG(16), .NUM_RD(4), .ZERO_REG(0)) u_b (
    .Clk(Clk), .reset_n(reset_n),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_pending(b_rd_pend),
    .sb_set_en(b_sb_set_en), .sb_set_addr(b_sb_set_addr),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input int dut, input int kind, input int port, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.kind = kind; e.port = port; e.ev = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic a_idle();
    a_wr0_en = 1'b0; a_wr1_en = 1'b0; a_sb_set_en = 1'b0; a_clr_req = 1'b0;
  endtask

  task automatic b_idle();
    b_wr0_en = 1'b0; b_wr1_en = 1'b0; b_sb_set_en = 1'b0; b_clr_req = 1'b0;
  endtask

  task automatic run_clear(input int dut, input int n);
    tick();
    if (dut == 0) a_clr_req = 1'b1; else b_clr_req = 1'b1;
    chk(dut, K_BUSY, 0, 32'd0, "rc_req_busy");
    for (int k = 1; k <= n; k++) begin
      tick();
      a_clr_req = 1'b0; b_clr_req = 1'b0;
      chk(dut, K_BUSY, 0, 32'd1, "rc_busy");
      chk(dut, K_DONE, 0, 32'd0, "rc_no_done");
    end
    tick();
    chk(dut, K_DONE, 0, 32'd1, "rc_done");
    chk(dut, K_BUSY, 0, 32'd0, "rc_busy_off");
    tick();
    chk(dut, K_DONE, 0, 32'd0, "rc_done_off");
  endtask

  // Monitor: compare every expectation queued for the current cycle at the falling edge.
  initial begin
    exp_t        me;
    logic [31:0] act;
    forever begin
      @(negedge Clk);
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        me = q.pop_front();
        act = 32'hFFFF_FFFF;
        if (me.dut == 0) begin
          case (me.kind)
            K_DATA:  act = a_rd_data[me.port];
            K_PEND:  act = {31'd0, a_rd_pend[me.port]};
            K_BUSY:  act = {31'd0, a_clr_busy};
            default: act = {31'd0, a_clr_done};
          endcase
        end else begin
          case (me.kind)
            K_DATA:  act = b_rd_data[me.port];
            K_PEND:  act = {31'd0, b_rd_pend[me.port]};
            K_BUSY:  act = {31'd0, b_clr_busy};
            default: act = {31'd0, b_clr_done};
          endcase
        end
        n_tests++;
        if (act !== me.ev) begin
          n_fail++;
          $display("FAIL %s dut%0d port%0d cyc%0d: got 0x%08h expected 0x%08h",
                   me.name, me.dut, me.port, cyc, act, me.ev);
        end
      end
    end
  end

  initial begin
    a_idle(); b_idle();
    a_wr0_addr = '0; a_wr1_addr = '0; a_sb_set_addr = '0; a_wr0_data = '0; a_wr1_data = '0;
    b_wr0_addr = '0; b_wr1_addr = '0; b_sb_set_addr = '0; b_wr0_data = '0; b_wr1_data = '0;
    a_rd_addr = '0; b_rd_addr = '0;
    reset_n = 1'b0;

    // reset state
    tick();
    a_rd_addr[0] = 5'd5; a_rd_addr[1] = 5'd3;
    chk(0, K_DATA, 0, 32'd0, "rst_data");
    chk(0, K_PEND, 1, 32'd0, "rst_pend");
    chk(0, K_BUSY, 0, 32'd0, "rst_busy");
    chk(0, K_DONE, 0, 32'd0, "rst_done");
    chk(1, K_BUSY, 0, 32'd0, "rst_b_busy");
    tick(); tick();
    reset_n = 1'b1;

    // basic write/read and hardwired x0
    tick();
    a_wr0_en = 1'b1; a_wr0_addr = 5'd5; a_wr0_data = 32'hDEAD_BEEF; a_rd_addr[0] = 5'd5;
    chk(0, K_DATA, 0, 32'hDEAD_BEEF, "t1_byp_x5");
    tick();
    a_wr0_addr = 5'd0; a_wr0_data = 32'h0000_1234; a_rd_addr[1] = 5'd0;
    chk(0, K_DATA, 0, 32'hDEAD_BEEF, "t1_rd_x5");
    chk(0, K_DATA, 1, 32'd0, "t1_x0_no_byp");
    tick();
    a_idle(); a_rd_addr[0] = 5'd0;
    chk(0, K_DATA, 0, 32'd0, "t1_x0");

    // dual-write priority and bypass
    tick();
    a_wr0_en = 1'b1; a_wr0_addr = 5'd7; a_wr0_data = 32'h11;
    a_wr1_en = 1'b1; a_wr1_addr = 5'd7; a_wr1_data = 32'h22;
    a_rd_addr[0] = 5'd5; a_rd_addr[1] = 5'd7;
    chk(0, K_DATA, 1, 32'h22, "t2_byp_wr1_wins");
    chk(0, K_DATA, 0, 32'hDEAD_BEEF, "t2_x5");
    tick();
    a_wr0_addr = 5'd8; a_wr0_data = 32'hAA; a_wr1_addr = 5'd9; a_wr1_data = 32'hBB;
    a_rd_addr[0] = 5'd8; a_rd_addr[1] = 5'd9;
    chk(0, K_DATA, 0, 32'hAA, "t2_byp_wr0");
    chk(0, K_DATA, 1, 32'hBB, "t2_byp_wr1");
    tick();
    a_idle(); a_rd_addr[0] = 5'd7;
    chk(0, K_DATA, 0, 32'h22, "t2_x7_stored");
    chk(0, K_DATA, 1, 32'hBB, "t2_x9_stored");
    tick();
    a_rd_addr[0] = 5'd8;
    chk(0, K_DATA, 0, 32'hAA, "t2_x8_stored");

    // scoreboard
    tick();
    a_sb_set_en = 1'b1; a_sb_set_addr = 5'd3; a_rd_addr[0] = 5'd3; a_rd_addr[1] = 5'd4;
    chk(0, K_PEND, 0, 32'd0, "t3_before_set");
    tick();
    a_idle();
    chk(0, K_PEND, 0, 32'd1, "t3_set");
    chk(0, K_PEND, 1, 32'd0, "t3_x4_clear");
    tick();
    a_wr0_en = 1'b1; a_wr0_addr = 5'd3; a_wr0_data = 32'h33;
    chk(0, K_PEND, 0, 32'd0, "t3_byp_hides_pend");
    chk(0, K_DATA, 0, 32'h33, "t3_byp_data");
    tick();
    a_idle();
    chk(0, K_PEND, 0, 32'd0, "t3_write_clears");
    chk(0, K_DATA, 0, 32'h33, "t3_x3_stored");
    tick();
    a_sb_set_en = 1'b1; a_sb_set_addr = 5'd3;
    a_wr1_en = 1'b1; a_wr1_addr = 5'd3; a_wr1_data = 32'h44;
    chk(0, K_PEND, 0, 32'd0, "t3_setwr_byp");
    chk(0, K_DATA, 0, 32'h44, "t3_setwr_data");
    tick();
    a_idle();
    chk(0, K_PEND, 0, 32'd1, "t3_set_wins");
    chk(0, K_DATA, 0, 32'h44, "t3_x3_44");
    tick();
    a_sb_set_en = 1'b1; a_sb_set_addr = 5'd0;
    tick();
    a_idle(); a_rd_addr[1] = 5'd0;
    chk(0, K_PEND, 1, 32'd0, "t3_x0_never_pend");

    // fill, then full clear with dropped writes and an ignored re-request
    for (int i = 1; i < 32; i++) begin
      tick();
      a_wr0_en = 1'b1; a_wr0_addr = 5'(i); a_wr0_data = 32'h1000_0000 | 32'(i);
    end
    tick();
    a_idle(); a_sb_set_en = 1'b1; a_sb_set_addr = 5'd10;
    tick();
    a_sb_set_addr = 5'd20;
    tick();
    a_idle(); a_rd_addr[0] = 5'd10; a_rd_addr[1] = 5'd20;
    chk(0, K_PEND, 0, 32'd1, "t4_pend_x10");
    chk(0, K_PEND, 1, 32'd1, "t4_pend_x20");
    chk(0, K_DATA, 0, 32'h1000_000A, "t4_x10_data");
    tick();
    a_clr_req = 1'b1; a_rd_addr[1] = 5'd10;
    chk(0, K_BUSY, 0, 32'd0, "t4_req_busy");
    for (int k = 1; k <= 32; k++) begin
      tick();
      a_clr_req = (k == 5);
      a_wr0_en = (k == 3); a_wr0_addr = 5'd5; a_wr0_data = 32'h0000_FFFF;
      a_rd_addr[0] = 5'd5;
      chk(0, K_BUSY, 0, 32'd1, "t4_busy");
      chk(0, K_DONE, 0, 32'd0, "t4_no_done");
      if (k == 3) begin
        chk(0, K_DATA, 0, 32'h1000_0005, "t4_no_byp_in_clear");
        chk(0, K_PEND, 1, 32'd1, "t4_pend_in_clear");
      end
    end
    tick();
    a_clr_req = 1'b0; a_wr0_en = 1'b1; a_wr0_addr = 5'd6; a_wr0_data = 32'h66; a_rd_addr[1] = 5'd6;
    chk(0, K_DONE, 0, 32'd1, "t4_done");
    chk(0, K_BUSY, 0, 32'd0, "t4_busy_off");
    chk(0, K_DATA, 1, 32'd0, "t4_no_byp_in_done");
    tick();
    a_idle();
    chk(0, K_DONE, 0, 32'd0, "t4_done_pulse");
    for (int i = 0; i < 32; i++) begin
      tick();
      a_rd_addr[0] = 5'(i); a_rd_addr[1] = 5'(i);
      chk(0, K_DATA, 0, 32'd0, "t4_cleared_data");
      chk(0, K_PEND, 1, 32'd0, "t4_cleared_pend");
      chk(0, K_BUSY, 0, 32'd0, "t4_no_restart");
    end

    // reset during CLEAR
    tick();
    a_wr1_en = 1'b1; a_wr1_addr = 5'd12; a_wr1_data = 32'h0000_0C0C;
    a_sb_set_en = 1'b1; a_sb_set_addr = 5'd13;
    tick();
    a_idle(); a_rd_addr[0] = 5'd12; a_rd_addr[1] = 5'd13;
    chk(0, K_DATA, 0, 32'h0000_0C0C, "t5_x12");
    chk(0, K_PEND, 1, 32'd1, "t5_pend_x13");
    tick();
    a_clr_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      a_clr_req = 1'b0;
      chk(0, K_BUSY, 0, 32'd1, "t5_busy");
    end
    tick();
    reset_n = 1'b0;
    chk(0, K_BUSY, 0, 32'd0, "t5_rst_busy");
    chk(0, K_DATA, 0, 32'd0, "t5_rst_x12");
    chk(0, K_PEND, 1, 32'd0, "t5_rst_pend");
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk(0, K_BUSY, 0, 32'd0, "t5_idle_busy");
      chk(0, K_DONE, 0, 32'd0, "t5_no_done");
    end
    run_clear(0, 32);

    // second instance: 4 ports, 16 registers, writable x0
    tick();
    b_wr0_en = 1'b1; b_wr0_addr = 4'd0; b_wr0_data = 32'hA5A5_A5A5; b_rd_addr = '0;
    for (int p = 0; p < 4; p++) chk(1, K_DATA, p, 32'hA5A5_A5A5, "t6_byp_x0");
    tick();
    b_idle();
    for (int p = 0; p < 4; p++) chk(1, K_DATA, p, 32'hA5A5_A5A5, "t6_x0_stored");
    tick();
    b_wr0_en = 1'b1; b_wr0_addr = 4'd1; b_wr0_data = 32'h1111;
    b_wr1_en = 1'b1; b_wr1_addr = 4'd2; b_wr1_data = 32'h2222;
    for (int p = 0; p < 4; p++) b_rd_addr[p] = 4'(p);
    chk(1, K_DATA, 0, 32'hA5A5_A5A5, "t6_p0_stored");
    chk(1, K_DATA, 1, 32'h1111, "t6_p1_byp0");
    chk(1, K_DATA, 2, 32'h2222, "t6_p2_byp1");
    chk(1, K_DATA, 3, 32'd0, "t6_p3_none");
    tick();
    b_idle(); b_sb_set_en = 1'b1; b_sb_set_addr = 4'd0;
    chk(1, K_DATA, 1, 32'h1111, "t6_x1_stored");
    chk(1, K_DATA, 2, 32'h2222, "t6_x2_stored");
    tick();
    b_idle();
    chk(1, K_PEND, 0, 32'd1, "t6_x0_pend");
    chk(1, K_PEND, 3, 32'd0, "t6_x3_no_pend");
    run_clear(1, 16);
    for (int i = 0; i < 16; i += 4) begin
      tick();
      for (int p = 0; p < 4; p++) begin
        b_rd_addr[p] = 4'(i + p);
        chk(1, K_DATA, p, 32'd0, "t6_cleared_data");
        chk(1, K_PEND, p, 32'd0, "t6_cleared_pend");
      end
    end

    tick();
    @(negedge Clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL unchecked_expectations: got %0d pending expected 0", q.size());
      n_tests += q.size();
      n_fail += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rfile_mp.md
Name: rfile_mp

Overview:
Parametrised successor to the single-write register file. Adds NUM_RD read ports, two write ports with fixed priority, and write-to-read bypass. Adds a per-register pending scoreboard for hazard detection and a sequenced hardware clear engine. Sits in the decode stage of the RISC-V core: read ports feed operand fetch, write ports take writeback from the ALU and load pipes.

Parameters:
DATA_WIDTH, 32, register width in bits
NUM_REG, 32, number of architectural registers
ADDR_WIDTH, $clog2(NUM_REG), register address width
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is ordinary storage

Ports:
Clk  input  1  clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
wr0_en  input  1  write port 0 enable (ALU writeback)
wr0_addr  input  ADDR_WIDTH  write port 0 address
wr0_data  input  DATA_WIDTH  write port 0 data
wr1_en  input  1  write port 1 enable (load writeback); wins over port 0
wr1_addr  input  ADDR_WIDTH  write port 1 address
wr1_data  input  DATA_WIDTH  write port 1 data
rd_addr  input  NUM_RD x ADDR_WIDTH  read addresses
rd_data  output  NUM_RD x DATA_WIDTH  read data (combinational)
rd_pending  output  NUM_RD  selected register has an outstanding producer
sb_set_en  input  1  mark a register pending (instruction issue)
sb_set_addr  input  ADDR_WIDTH  register to mark pending
clr_req  input  1  request a full register-file clear
clr_busy  output  1  clear sequence in progress
clr_done  output  1  one-cycle pulse when the clear completes

Behaviour:
- Reset: the reset is asynchronous and active-low (reset_n), on the single clock Clk. While reset_n=0:
  - all registers = 0, all scoreboard bits = 0;
  - FSM = IDLE, clear pointer = 0;
  - clr_busy = 0, clr_done = 0.
- Writes (state IDLE only), applied at posedge:
  - wr0 and wr1 to the same address in one cycle: wr1_data is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads: combinational, zero latency.
  - Bypass: if a write is enabled this cycle to rd_addr[i] (and not dropped), rd_data[i] = that write data; wr1 beats wr0.
  - Otherwise rd_data[i] = stored value.
  - With ZERO_REG=1, address 0 always reads 0.
- Scoreboard, one bit per register, updated at posedge in IDLE only:
  - sb_set_en sets bit[sb_set_addr].
  - Any enabled, non-dropped write to address A clears bit[A].
  - Set and write to the same address in the same cycle: the set wins (new producer), so the bit stays 1.
  - With ZERO_REG=1, bit 0 is never set.
- rd_pending[i] = bit[rd_addr[i]] AND NOT (a bypass hit on port i this cycle).
- Clear FSM, states IDLE -> CLEAR -> DONE -> IDLE:
  - IDLE -> CLEAR on clr_req=1; the pointer loads 0.
  - CLEAR: clr_busy=1. Each cycle, register[ptr] = 0, bit[ptr] = 0, ptr++. After ptr = NUM_REG-1 is cleared, go to DONE.
  - DONE: clr_done=1 for exactly one cycle, clr_busy=0, then IDLE.
  - Latency: clr_req sampled at edge t gives clr_busy=1 for cycles t+1..t+NUM_REG and clr_done=1 in cycle t+NUM_REG+1.
  - clr_req while in CLEAR or DONE is ignored (no restart, no queuing).
  - In CLEAR and DONE, wr0/wr1/sb_set_en are dropped. Reads return stored contents with no bypass, and rd_pending reflects current bits.
  - Reset mid-CLEAR aborts to IDLE with everything zeroed. No clr_done is issued.
- Width rules:
  - The pointer is ADDR_WIDTH+1 bits, so NUM_REG equal to a power of two terminates without wrap.
  - Addresses >= NUM_REG (non-power-of-two NUM_REG) are dropped on write and read as 0.

Decomposition:
- Package rfile_pkg: state enum rf_clr_state_e {IDLE, CLEAR, DONE}, plus default width constants (DATA_WIDTH=32, NUM_REG=32) shared with the decode stage.
- Sub-module rfile_clr_fsm: holds the state, the pointer, clr_busy and clr_done. It outputs clr_we and clr_addr into the storage/scoreboard logic in rfile_mp.

Test Plan:
1. Reset, then wr0 writes 0xDEADBEEF to x5 at edge 1; next cycle rd_addr[0]=5 reads 0xDEADBEEF. A wr0 write of 0x1234 to x0 is followed by a read of x0 returning 0.
2. Same cycle: wr0 writes 0x11 and wr1 writes 0x22, both to x7, while rd_addr[1]=7 -> rd_data[1]=0x22 combinationally (bypass), and x7 holds 0x22 after the edge.
3. sb_set x3 -> rd_pending=1 on a port reading x3. wr0 writes x3 -> rd_pending=0 during the write cycle (bypass) and after it. sb_set x3 together with a wr1 write to x3 -> bit stays 1.
4. Fill x1..x31 with nonzero values and set several scoreboard bits, then pulse clr_req -> clr_busy high for exactly 32 cycles, clr_done one pulse in cycle 33, all registers and bits read 0. A wr0 write issued during CLEAR is lost.
5. Pulse clr_req, then at cycle 10 of CLEAR pulse reset_n low for 1 cycle -> state IDLE, clr_busy=0, no clr_done, all reads 0. A later clr_req runs a full 32-cycle sequence.
6. Parameter sweep NUM_RD=4, NUM_REG=16, ZERO_REG=0 -> x0 is writable and reads back 0xA5A5A5A5, the clear takes 16 cycles, and all 4 ports bypass independently.
